// File: rtl/audio_pkg.sv
// audio_pkg: shared audio types for the CODEC filter path.
//   SAMPLE_W       default audio sample width (two's complement)
//   sample_t       signed audio sample
//   filter_state_t read / calculate / write sequencing states
package audio_pkg;

   localparam int SAMPLE_W = 24;

   typedef logic signed [SAMPLE_W-1:0] sample_t;

   typedef enum logic [1:0] {
      S_READ,
      S_CALC,
      S_WRITE
   } filter_state_t;

endpackage

// File: rtl/maf_channel.sv
// maf_channel: one channel of an N-point moving average, N = 2**LOG2N.
// Every input sample is pre-divided by N. The window holds the last N divided
// samples, and a running sum is kept so that each update costs one add and one
// subtract.
//   clk        system clock
//   reset      synchronous, active-high; clears window, sum and pointer
//   en         one-cycle strobe: absorb sample_in into the window
//   sample_in  signed input sample
//   avg_out    registered running average
module maf_channel #(
   parameter int SAMPLE_W = 24,
   parameter int LOG2N    = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       en,
   input  logic signed [SAMPLE_W-1:0] sample_in,
   output logic signed [SAMPLE_W-1:0] avg_out
);

   localparam int N = 2 ** LOG2N;

   logic signed [SAMPLE_W-1:0] win_buf [N];
   logic signed [SAMPLE_W-1:0] acc;
   logic signed [SAMPLE_W-1:0] d;
   logic        [LOG2N-1:0]    ptr;

   // Arithmetic shift rounds toward -inf, so the sum of N terms stays inside
   // SAMPLE_W bits and no saturation is required.
   assign d = sample_in >>> LOG2N;

   // The pointer is exactly LOG2N bits wide, so it wraps N-1 -> 0 on its own.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc <= '0;
         ptr <= '0;
         for (int i = 0; i < N; i++) begin
            win_buf[i] <= '0;
         end
      end else if (en) begin
         acc          <= acc + d - win_buf[ptr];
         win_buf[ptr] <= d;
         ptr          <= ptr + 1'b1;
      end
   end

   assign avg_out = acc;

endmodule

// File: rtl/moving_average_filter.sv
// moving_average_filter: stereo N-point moving-average stage between the CODEC
// read port (mic-in) and write port (line-out). Each accepted sample yields
// exactly one filtered sample.
//   clk              system clock
//   reset            synchronous, active-high
//   read_ready       CODEC has a new mic-in sample
//   write_ready      CODEC can accept a line-out sample
//   readdata_left    mic-in sample, left
//   readdata_right   mic-in sample, right
//   read             sample consumed this cycle
//   write            writedata_* presented to CODEC this cycle
//   writedata_left   filtered sample, left
//   writedata_right  filtered sample, right
//
// state   | meaning
// S_READ  | waiting for read_ready; read follows read_ready
// S_CALC  | one cycle: both channels absorb the captured sample
// S_WRITE | averages presented; write follows write_ready
module moving_average_filter #(
   parameter int SAMPLE_W = 24,
   parameter int LOG2N    = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       read_ready,
   input  logic                       write_ready,
   input  logic signed [SAMPLE_W-1:0] readdata_left,
   input  logic signed [SAMPLE_W-1:0] readdata_right,
   output logic                       read,
   output logic                       write,
   output logic signed [SAMPLE_W-1:0] writedata_left,
   output logic signed [SAMPLE_W-1:0] writedata_right
);

   import audio_pkg::*;

   filter_state_t state;
   filter_state_t state_nxt;

   logic signed [SAMPLE_W-1:0] cap_left;
   logic signed [SAMPLE_W-1:0] cap_right;
   logic                       calc_en;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_READ;
         cap_left  <= '0;
         cap_right <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_READ && read_ready) begin
            cap_left  <= readdata_left;
            cap_right <= readdata_right;
         end
      end
   end

   // Handshakes are gated by reset so nothing is consumed or emitted while the
   // synchronous reset is pending.
   always_comb begin
      state_nxt = state;
      read      = 1'b0;
      write     = 1'b0;
      case (state)
         S_READ: begin
            read = read_ready && !reset;
            if (read_ready) state_nxt = S_CALC;
         end
         S_CALC: begin
            state_nxt = S_WRITE;
         end
         S_WRITE: begin
            write = write_ready && !reset;
            if (write_ready) state_nxt = S_READ;
         end
         default: begin
            state_nxt = S_READ;
         end
      endcase
   end

   assign calc_en = (state == S_CALC);

   // The channel accumulators are the output registers: they only change on the
   // S_CALC -> S_WRITE edge, so writedata_* holds through S_READ and S_CALC.
   maf_channel #(
      .SAMPLE_W (SAMPLE_W),
      .LOG2N    (LOG2N)
   ) u_left (
      .clk       (clk),
      .reset     (reset),
      .en        (calc_en),
      .sample_in (cap_left),
      .avg_out   (writedata_left)
   );

   maf_channel #(
      .SAMPLE_W (SAMPLE_W),
      .LOG2N    (LOG2N)
   ) u_right (
      .clk       (clk),
      .reset     (reset),
      .en        (calc_en),
      .sample_in (cap_right),
      .avg_out   (writedata_right)
   );

endmodule

// File: tb/tb_moving_average_filter.sv
module tb_moving_average_filter;

   localparam int SW    = 24;
   localparam int LOG2N = 2;
   localparam int N     = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          read_ready;
   logic          write_ready;
   logic [SW-1:0] readdata_left;
   logic [SW-1:0] readdata_right;
   logic          read;
   logic          write;
   logic [SW-1:0] writedata_left;
   logic [SW-1:0] writedata_right;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // model state
   int  hist_l [$];
   int  hist_r [$];
   int  cur_l = 0, cur_r = 0;
   int  nxt_l = 0, nxt_r = 0;
   int  due   = -1;
   bit  owed  = 1'b0;

   moving_average_filter #(.SAMPLE_W(SW), .LOG2N(LOG2N)) dut (
      .clk             (clk),
      .reset           (reset),
      .read_ready      (read_ready),
      .write_ready     (write_ready),
      .readdata_left   (readdata_left),
      .readdata_right  (readdata_right),
      .read            (read),
      .write           (write),
      .writedata_left  (writedata_left),
      .writedata_right (writedata_right)
   );

   always #5 clk = ~clk;

   function automatic void chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic int sx(input logic [SW-1:0] v);
      return int'($signed(v));
   endfunction

   function automatic void model_clear();
      hist_l.delete();
      hist_r.delete();
      for (int i = 0; i < N; i++) begin
         hist_l.push_back(0);
         hist_r.push_back(0);
      end
      cur_l = 0; cur_r = 0;
      due   = -1;
      owed  = 1'b0;
   endfunction

   // Output = sum of the last N samples, each divided by N with floor rounding.
   function automatic int window_sum(ref int q [$]);
      int s = 0;
      foreach (q[i]) s += q[i];
      return s;
   endfunction

   // Compare process: every cycle, at the falling edge.
   always @(negedge clk) begin
      cyc++;
      if (reset) begin
         chk("read_in_reset", int'(read), 0);
         chk("write_in_reset", int'(write), 0);
         model_clear();
      end else begin
         if (cyc == due) begin
            cur_l = nxt_l;
            cur_r = nxt_r;
         end
         chk("wd_left", sx(writedata_left), cur_l);
         chk("wd_right", sx(writedata_right), cur_r);
         if (read && write) chk("read_and_write", 1, 0);
         if (write && (!owed || cyc < due)) chk("write_early", int'(write), 0);
         if (read && owed) chk("read_while_owed", int'(read), 0);
         if (write) owed = 1'b0;
         if (read) begin
            hist_l.push_back(sx(readdata_left) >>> LOG2N);
            hist_r.push_back(sx(readdata_right) >>> LOG2N);
            void'(hist_l.pop_front());
            void'(hist_r.pop_front());
            nxt_l = window_sum(hist_l);
            nxt_r = window_sum(hist_r);
            due   = cyc + 2;
            owed  = 1'b1;
         end
      end
   end

   // One CODEC transaction: offer a sample, wait out `stall` S_WRITE cycles
   // with write_ready low, then accept the output.
   task automatic send(input int l, input int r, input int stall, input bit rr_hold,
                       output int ol, output int orr);
      int n;
      int tr;
      @(posedge clk); #1;
      readdata_left  = SW'(l);
      readdata_right = SW'(r);
      read_ready     = 1'b1;
      write_ready    = 1'b0;
      n = 0;
      @(negedge clk);
      while (!read && n < 20) begin
         n++;
         @(negedge clk);
      end
      chk("read_latency", n, 0);
      tr = cyc;
      @(posedge clk); #1;
      if (!rr_hold) read_ready = 1'b0;
      for (int i = 0; i < stall + 1; i++) begin
         @(negedge clk);
         chk("stall_read", int'(read), 0);
         chk("stall_write", int'(write), 0);
         @(posedge clk); #1;
      end
      read_ready  = 1'b0;
      write_ready = 1'b1;
      n = 0;
      @(negedge clk);
      while (!write && n < 20) begin
         n++;
         @(negedge clk);
      end
      chk("write_delay", cyc - tr, 2 + stall);
      ol  = sx(writedata_left);
      orr = sx(writedata_right);
      @(posedge clk); #1;
      @(negedge clk);
      chk("write_once", int'(write), 0);
      write_ready = 1'b0;
   endtask

   int ol, orr;
   int exp_step_l [5] = '{100, 200, 300, 400, 400};
   int exp_decay  [4] = '{300, 200, 100, 0};
   int exp_round  [4] = '{-1, -2, -3, -4};
   int exp_max    [4] = '{2097148, 4194300, 6291452, 8388604};
   int n;

   initial begin
      model_clear();
      reset          = 1'b1;
      read_ready     = 1'b0;
      write_ready    = 1'b0;
      readdata_left  = '0;
      readdata_right = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("reset_read", int'(read), 0);
      chk("reset_write", int'(write), 0);
      chk("reset_wd_left", sx(writedata_left), 0);

      // Step response
      for (int i = 0; i < 5; i++) begin
         send(400, -400, 0, 1'b0, ol, orr);
         chk("step_left", ol, exp_step_l[i]);
         chk("step_right", orr, -exp_step_l[i]);
      end
      // Decay back to zero through the pointer wrap
      for (int i = 0; i < 4; i++) begin
         send(0, 0, 0, 1'b0, ol, orr);
         chk("decay_left", ol, exp_decay[i]);
      end
      // Floor rounding of negatives, then full-scale positive
      for (int i = 0; i < 4; i++) begin
         send(-3, 0, 0, 1'b0, ol, orr);
         chk("round_left", ol, exp_round[i]);
      end
      for (int i = 0; i < 4; i++) begin
         send(8388607, 0, 0, 1'b0, ol, orr);
         chk("max_left", ol, exp_max[i]);
      end
      // Backpressure with read_ready held high
      send(-8388608, 123, 10, 1'b1, ol, orr);

      // Randomized traffic with random stalls
      for (int i = 0; i < 40; i++) begin
         send(sx(SW'($urandom)), sx(SW'($urandom)), int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), ol, orr);
      end

      // Reset in S_WRITE with a pending output
      reset_model_seq();
      send(400, 400, 0, 1'b0, ol, orr);
      chk("post_reset_left", ol, 100);
      chk("post_reset_right", orr, 100);

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   task automatic reset_model_seq();
      int l1, r1;
      send(400, 400, 0, 1'b0, l1, r1);
      send(400, 400, 0, 1'b0, l1, r1);
      @(posedge clk); #1;
      readdata_left  = SW'(400);
      readdata_right = SW'(400);
      read_ready     = 1'b1;
      n = 0;
      @(negedge clk);
      while (!read && n < 20) begin
         n++;
         @(negedge clk);
      end
      chk("rst_seq_read", int'(read), 1);
      @(posedge clk); #1 read_ready = 1'b0;   // S_CALC
      @(posedge clk); #1;                     // S_WRITE, write_ready low
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk);
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_read", int'(read), 0);
      chk("rst_write", int'(write), 0);
      chk("rst_wd_left", sx(writedata_left), 0);
      chk("rst_wd_right", sx(writedata_right), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule
